// File: rtl/iicmb_pkg.sv
// Register map, command codes and status bit positions of the iicmb I2C core,
// plus the sequencer state encoding shared by the RTL and its bench.
package iicmb_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam logic [2:0] CMD_WAIT     = 3'd0;
    localparam logic [2:0] CMD_WRITE    = 3'd1;
    localparam logic [2:0] CMD_READ_AK  = 3'd2;
    localparam logic [2:0] CMD_READ_NAK = 3'd3;
    localparam logic [2:0] CMD_START    = 3'd4;
    localparam logic [2:0] CMD_STOP     = 3'd5;
    localparam logic [2:0] CMD_SET_BUS  = 3'd6;

    localparam logic [7:0] CSR_E  = 8'h80;
    localparam logic [7:0] CSR_IE = 8'h40;

    localparam int ST_DON = 7;
    localparam int ST_NAK = 6;
    localparam int ST_AL  = 5;
    localparam int ST_ERR = 4;

    typedef enum logic [3:0] {
        S_INIT_CSR = 4'd0,
        S_INIT_DPR = 4'd1,
        S_INIT_CMD = 4'd2,
        S_IDLE     = 4'd3,
        S_START    = 4'd4,
        S_ADDR_DPR = 4'd5,
        S_ADDR_CMD = 4'd6,
        S_WR_DPR   = 4'd7,
        S_WR_CMD   = 4'd8,
        S_RD_CMD   = 4'd9,
        S_RD_DPR   = 4'd10,
        S_RD_OUT   = 4'd11,
        S_STOP     = 4'd12,
        S_DONE     = 4'd13,
        S_WAIT     = 4'd14
    } seq_state_t;

    function automatic logic status_bad(input logic [7:0] st);
        return st[ST_NAK] | st[ST_AL] | st[ST_ERR];
    endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single-access Wishbone master: a start pulse opens one cycle that is held
// until ack_i, then everything drops and done_o pulses with the read data.
module wb_master_port #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [WB_ADDR_WIDTH-1:0] addr_i,
    input  logic                     we_i,
    input  logic [WB_DATA_WIDTH-1:0] wdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [WB_DATA_WIDTH-1:0] rdata_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i
);

    logic                     r_cyc;
    logic                     r_we;
    logic [WB_ADDR_WIDTH-1:0] r_adr;
    logic [WB_DATA_WIDTH-1:0] r_dat;
    logic                     r_done;
    logic [WB_DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_cyc) begin
                // Address, direction and data stay frozen until the ack is seen.
                if (ack_i) begin
                    r_cyc   <= 1'b0;
                    r_we    <= 1'b0;
                    r_adr   <= '0;
                    r_dat   <= '0;
                    r_done  <= 1'b1;
                    r_rdata <= dat_i;
                end
            end else if (start_i) begin
                r_cyc <= 1'b1;
                r_we  <= we_i;
                r_adr <= addr_i;
                r_dat <= wdata_i;
            end
        end
    end

    assign busy_o  = r_cyc;
    assign done_o  = r_done;
    assign rdata_o = r_rdata;
    assign cyc_o   = r_cyc;
    assign stb_o   = r_cyc;
    assign we_o    = r_we;
    assign adr_o   = r_adr;
    assign dat_o   = r_dat;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Drives an iicmb I2C core over Wishbone: initialises the core, then turns
// request/byte-stream transfers into START/ADDR/data/STOP command sequences.
module i2c_wb_sequencer
    import iicmb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8,
    parameter int BUS_ID        = 5,
    parameter int MAX_LEN       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_op_i,
    input  logic [6:0]               req_addr_i,
    input  logic [5:0]               req_len_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [7:0]               wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [7:0]               rd_data_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i,
    output seq_state_t               dbg_state_o
);

    seq_state_t r_state;
    seq_state_t r_next;
    logic       r_pend;
    logic       r_op;
    logic [6:0] r_addr;
    logic [5:0] r_count;
    logic       r_err;
    logic       r_err_o;
    logic       r_done;
    logic       r_req_ready;
    logic       r_wr_ready;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;

    logic                     w_acc;
    logic                     w_gate;
    logic                     w_we;
    logic [1:0]               w_reg;
    logic [7:0]               w_wdata;
    logic                     w_start;
    logic                     w_busy;
    logic                     w_done;
    logic [WB_DATA_WIDTH-1:0] w_rdata;
    logic                     w_bad;
    logic                     w_len_bad;
    logic                     w_in_xfer;

    // Which register access the current state performs, and what gates it.
    always_comb begin
        w_acc   = 1'b1;
        w_gate  = 1'b1;
        w_we    = 1'b1;
        w_reg   = REG_CMDR;
        w_wdata = 8'h00;
        case (r_state)
            S_INIT_CSR: begin w_reg = REG_CSR; w_wdata = CSR_E | CSR_IE; end
            S_INIT_DPR: begin w_reg = REG_DPR; w_wdata = 8'(BUS_ID); end
            S_INIT_CMD: w_wdata = {5'd0, CMD_SET_BUS};
            S_START:    w_wdata = {5'd0, CMD_START};
            S_ADDR_DPR: begin w_reg = REG_DPR; w_wdata = {r_addr, r_op}; end
            S_ADDR_CMD: w_wdata = {5'd0, CMD_WRITE};
            S_WR_DPR: begin
                w_reg   = REG_DPR;
                w_wdata = wr_data_i;
                w_gate  = r_wr_ready & wr_valid_i;
            end
            S_WR_CMD:   w_wdata = {5'd0, CMD_WRITE};
            S_RD_CMD:   w_wdata = {5'd0, (r_count == 6'd1) ? CMD_READ_NAK : CMD_READ_AK};
            S_RD_DPR: begin w_reg = REG_DPR; w_we = 1'b0; end
            S_STOP:     w_wdata = {5'd0, CMD_STOP};
            S_WAIT: begin w_we = 1'b0; w_gate = irq_i; end
            default:    w_acc = 1'b0;
        endcase
    end

    assign w_start   = w_acc & w_gate & ~r_pend & ~w_busy;
    assign w_bad     = status_bad(w_rdata[7:0]);
    assign w_len_bad = (req_len_i == 6'd0) || (int'(req_len_i) > MAX_LEN);
    assign w_in_xfer = (r_next != S_IDLE) && (r_next != S_DONE);

    wb_master_port #(
        .WB_ADDR_WIDTH(WB_ADDR_WIDTH),
        .WB_DATA_WIDTH(WB_DATA_WIDTH)
    ) u_port (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(w_start),
        .addr_i (WB_ADDR_WIDTH'(w_reg)),
        .we_i   (w_we),
        .wdata_i(WB_DATA_WIDTH'(w_wdata)),
        .busy_o (w_busy),
        .done_o (w_done),
        .rdata_o(w_rdata),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_INIT_CSR;
            r_next      <= S_IDLE;
            r_pend      <= 1'b0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_o     <= 1'b0;
            r_done      <= 1'b0;
            r_req_ready <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err_o <= 1'b0;
            if (w_start) r_pend <= 1'b1;
            if (w_done)  r_pend <= 1'b0;
            case (r_state)
                S_INIT_CSR: if (w_done) r_state <= S_INIT_DPR;
                S_INIT_DPR: if (w_done) r_state <= S_INIT_CMD;
                S_INIT_CMD: if (w_done) begin r_state <= S_WAIT; r_next <= S_IDLE; end
                S_IDLE: if (req_valid_i && r_req_ready) begin
                    r_req_ready <= 1'b0;
                    r_op        <= req_op_i;
                    r_addr      <= req_addr_i;
                    r_count     <= req_len_i;
                    r_err       <= 1'b0;
                    if (w_len_bad) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err_o <= 1'b1;
                    end else begin
                        r_state <= S_START;
                    end
                end
                S_START:    if (w_done) begin r_state <= S_WAIT; r_next <= S_ADDR_DPR; end
                S_ADDR_DPR: if (w_done) r_state <= S_ADDR_CMD;
                S_ADDR_CMD: if (w_done) begin
                    r_state <= S_WAIT;
                    r_next  <= r_op ? S_RD_CMD : S_WR_DPR;
                end
                S_WR_DPR: begin
                    if (w_start) r_wr_ready <= 1'b0;
                    if (w_done)  r_state <= S_WR_CMD;
                end
                S_WR_CMD: if (w_done) begin
                    r_state <= S_WAIT;
                    r_next  <= (r_count == 6'd1) ? S_STOP : S_WR_DPR;
                    r_count <= r_count - 6'd1;
                end
                S_RD_CMD: if (w_done) begin r_state <= S_WAIT; r_next <= S_RD_DPR; end
                S_RD_DPR: if (w_done) begin
                    r_rd_data  <= w_rdata[7:0];
                    r_rd_valid <= 1'b1;
                    r_count    <= r_count - 6'd1;
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: if (rd_ready_i) begin
                    r_rd_valid <= 1'b0;
                    r_state    <= (r_count == 6'd0) ? S_STOP : S_RD_CMD;
                end
                S_STOP: if (w_done) begin r_state <= S_WAIT; r_next <= S_DONE; end
                S_WAIT: if (w_done) begin
                    // A bad status mid-transfer abandons the remaining bytes.
                    if (w_bad) r_err <= 1'b1;
                    if (w_bad && w_in_xfer) begin
                        r_state <= S_STOP;
                    end else begin
                        r_state <= r_next;
                        case (r_next)
                            S_IDLE:   r_req_ready <= 1'b1;
                            S_WR_DPR: r_wr_ready  <= 1'b1;
                            S_DONE: begin
                                r_done  <= 1'b1;
                                r_err_o <= r_err | w_bad;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= S_INIT_CSR;
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign wr_ready_o  = r_wr_ready;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = r_rd_data;
    assign done_o      = r_done;
    assign err_o       = r_err_o;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench for i2c_wb_sequencer with a behavioural iicmb core and
// I2C slave at address 0x22 answering on the Wishbone side.
module tb_i2c_wb_sequencer;
    import iicmb_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_op_i = 1'b0;
    logic [6:0] req_addr_i = '0;
    logic [5:0] req_len_i = '0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [7:0] wr_data_i = '0;
    logic       rd_valid_o;
    logic       rd_ready_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       done_o;
    logic       err_o;
    logic       cyc_o;
    logic       stb_o;
    logic       we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i = '0;
    logic       ack_i = 1'b0;
    logic       irq_i = 1'b0;
    seq_state_t dbg_state_o;

    always #5 clk_i = ~clk_i;

    i2c_wb_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .done_o(done_o), .err_o(err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i), .dbg_state_o(dbg_state_o)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic [7:0]  rx_q[$];

    // Core model state; m_base is the only field written by the tests.
    logic [7:0]  m_dpr = '0;
    logic [7:0]  m_status = '0;
    logic [7:0]  m_base = 8'd100;
    logic [7:0]  m_rd_cnt = '0;
    logic        m_addr_phase = 1'b0;
    logic        m_seen = 1'b0;
    logic [10:0] m_snap = '0;
    int          m_irq_cnt = 0;
    int          m_unstable = 0;

    // Each WB cycle is acked on its second low phase so held signals can be checked.
    always @(negedge clk_i) begin
        if (rst_i) begin
            ack_i = 1'b0; irq_i = 1'b0; m_irq_cnt = 0; m_seen = 1'b0; m_addr_phase = 1'b0;
        end else begin
            if (ack_i) begin
                ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                if (!m_seen) begin
                    m_seen = 1'b1;
                    m_snap = {we_o, adr_o, dat_o};
                end else begin
                    m_seen = 1'b0;
                    if ({we_o, adr_o, dat_o} !== m_snap) m_unstable++;
                    ack_i = 1'b1;
                    if (we_o) begin
                        if (adr_o == REG_DPR) m_dpr = dat_o;
                        if (adr_o == REG_CMDR) begin
                            m_irq_cnt = 3;
                            m_status  = 8'h80;
                            case (dat_o[2:0])
                                CMD_START: begin m_addr_phase = 1'b1; m_rd_cnt = '0; end
                                CMD_WRITE: begin
                                    if (m_addr_phase) begin
                                        m_addr_phase = 1'b0;
                                        if (m_dpr[7:1] != 7'h22) m_status = 8'h40;
                                    end else begin
                                        rx_q.push_back(m_dpr);
                                    end
                                end
                                CMD_READ_AK, CMD_READ_NAK: begin
                                    m_dpr = m_base + m_rd_cnt;
                                    m_rd_cnt++;
                                end
                                default: ;
                            endcase
                        end
                        obs_q.push_back({1'b1, adr_o, dat_o});
                    end else begin
                        dat_i = (adr_o == REG_CMDR) ? m_status : (adr_o == REG_DPR) ? m_dpr : 8'h00;
                        if (adr_o == REG_CMDR) irq_i = 1'b0;
                        obs_q.push_back({1'b0, adr_o, dat_i});
                    end
                end
            end
            if (m_irq_cnt > 0) begin
                m_irq_cnt--;
                if (m_irq_cnt == 0) irq_i = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exp_push(input logic we, input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({we, a, d});
    endtask

    task automatic push_init_seq();
        exp_push(1, REG_CSR, 8'hC0);
        exp_push(1, REG_DPR, 8'h05);
        exp_push(1, REG_CMDR, 8'h06);
        exp_push(0, REG_CMDR, 8'h80);
    endtask

    // Waits (bounded) for req_ready_o, then offers one request for one cycle.
    task automatic send_req(input logic op, input logic [6:0] a, input logic [5:0] len);
        int t;
        t = 0;
        while (!req_ready_o && t < 2000) begin @(negedge clk_i); t++; end
        if (!req_ready_o) begin
            n_vec++; n_err++;
            $display("FAIL req_ready_timeout: req_ready_o=%0b, required 1", req_ready_o);
        end
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_len_i = len;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(output logic got, output logic err, output logic saw_wr);
        got = 1'b0; err = 1'b0; saw_wr = 1'b0;
        for (int t = 0; t < 5000 && !got; t++) begin
            if (done_o) begin
                got = 1'b1; err = err_o;
            end else begin
                if (wr_ready_o) saw_wr = 1'b1;
                @(negedge clk_i);
            end
        end
    endtask

    task automatic test_reset();
        int t;
        repeat (3) @(negedge clk_i);
        n_vec++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o} !== 20'd0) begin
            n_err++; $display("FAIL reset_outputs: cyc=%b stb=%b we=%b adr=%h dat=%h rq=%b wr=%b rd=%b done=%b err=%b, required all 0",
                cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o);
        end
        n_vec++;
        if (dbg_state_o !== S_INIT_CSR) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dbg_state_o, S_INIT_CSR); end
        rst_i = 1'b0;
        t = 0;
        while (!req_ready_o && t < 2000) begin @(negedge clk_i); t++; end
        exp_q.delete();
        push_init_seq();
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL init_log_len: got %0d, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL init_log[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_write();
        int mark, rx_mark, t;
        logic got, err, saw_wr;
        mark = obs_q.size(); rx_mark = rx_q.size();
        send_req(1'b0, 7'h22, 6'd32);
        for (int i = 0; i < 32; i++) begin
            t = 0;
            while (!wr_ready_o && t < 2000) begin @(negedge clk_i); t++; end
            if (!wr_ready_o) begin n_vec++; n_err++; $display("FAIL wr_ready_timeout: byte %0d", i); break; end
            wr_valid_i = 1'b1; wr_data_i = 8'(i);
            @(negedge clk_i);
            wr_valid_i = 1'b0;
        end
        wait_done(got, err, saw_wr);
        n_vec++;
        if ({got, err} !== 2'b10) begin n_err++; $display("FAIL write_done: done=%b err=%b, required done=1 err=0", got, err); end
        exp_q.delete();
        exp_push(1, REG_CMDR, 8'h04); exp_push(0, REG_CMDR, 8'h80);
        exp_push(1, REG_DPR, 8'h44); exp_push(1, REG_CMDR, 8'h01); exp_push(0, REG_CMDR, 8'h80);
        for (int i = 0; i < 32; i++) begin
            exp_push(1, REG_DPR, 8'(i)); exp_push(1, REG_CMDR, 8'h01); exp_push(0, REG_CMDR, 8'h80);
        end
        exp_push(1, REG_CMDR, 8'h05); exp_push(0, REG_CMDR, 8'h80);
        n_vec++;
        if (obs_q.size() !== mark + exp_q.size()) begin n_err++; $display("FAIL write_log_len: got %0d, required %0d", obs_q.size() - mark, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && mark + i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[mark+i] !== exp_q[i]) begin n_err++; $display("FAIL write_log[%0d]: got %h, required %h", i, obs_q[mark+i], exp_q[i]); end
        end
        n_vec++;
        if (rx_q.size() !== rx_mark + 32) begin n_err++; $display("FAIL slave_rx_len: got %0d, required 32", rx_q.size() - rx_mark); end
        for (int i = 0; i < 32 && rx_mark + i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[rx_mark+i] !== 8'(i)) begin n_err++; $display("FAIL slave_rx[%0d]: got %h, required %h", i, rx_q[rx_mark+i], 8'(i)); end
        end
    endtask

    // Reads `len` bytes expecting base, base+1, ... with random consumer stalls.
    task automatic read_bytes(input int first, input int count, input logic [7:0] base);
        int t, stall;
        for (int k = first; k < first + count; k++) begin
            t = 0;
            while (!rd_valid_o && t < 2000) begin @(negedge clk_i); t++; end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk_i);
            n_vec++;
            if (rd_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_valid_hold: byte %0d rd_valid_o=%b, required 1", k, rd_valid_o); end
            n_vec++;
            if (rd_data_o !== base + 8'(k)) begin n_err++; $display("FAIL rd_data[%0d]: got %0d, required %0d", k, rd_data_o, base + 8'(k)); end
            rd_ready_i = 1'b1;
            @(negedge clk_i);
            rd_ready_i = 1'b0;
        end
    endtask

    task automatic test_read();
        int mark;
        logic got, err, saw_wr;
        mark = obs_q.size();
        m_base = 8'd100;
        send_req(1'b1, 7'h22, 6'd32);
        read_bytes(0, 32, 8'd100);
        wait_done(got, err, saw_wr);
        n_vec++;
        if ({got, err} !== 2'b10) begin n_err++; $display("FAIL read_done: done=%b err=%b, required done=1 err=0", got, err); end
        exp_q.delete();
        exp_push(1, REG_CMDR, 8'h04); exp_push(0, REG_CMDR, 8'h80);
        exp_push(1, REG_DPR, 8'h45); exp_push(1, REG_CMDR, 8'h01); exp_push(0, REG_CMDR, 8'h80);
        for (int k = 0; k < 32; k++) begin
            exp_push(1, REG_CMDR, (k == 31) ? 8'h03 : 8'h02);
            exp_push(0, REG_CMDR, 8'h80);
            exp_push(0, REG_DPR, 8'(100 + k));
        end
        exp_push(1, REG_CMDR, 8'h05); exp_push(0, REG_CMDR, 8'h80);
        n_vec++;
        if (obs_q.size() !== mark + exp_q.size()) begin n_err++; $display("FAIL read_log_len: got %0d, required %0d", obs_q.size() - mark, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && mark + i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[mark+i] !== exp_q[i]) begin n_err++; $display("FAIL read_log[%0d]: got %h, required %h", i, obs_q[mark+i], exp_q[i]); end
        end
    endtask

    task automatic test_nak();
        int mark;
        logic got, err, saw_wr;
        mark = obs_q.size();
        send_req(1'b0, 7'h23, 6'd4);
        wait_done(got, err, saw_wr);
        n_vec++;
        if ({got, err} !== 2'b11) begin n_err++; $display("FAIL nak_done: done=%b err=%b, required done=1 err=1", got, err); end
        n_vec++;
        if (saw_wr !== 1'b0) begin n_err++; $display("FAIL nak_wr_ready: wr_ready_o seen=%b, required 0", saw_wr); end
        exp_q.delete();
        exp_push(1, REG_CMDR, 8'h04); exp_push(0, REG_CMDR, 8'h80);
        exp_push(1, REG_DPR, 8'h46); exp_push(1, REG_CMDR, 8'h01); exp_push(0, REG_CMDR, 8'h40);
        exp_push(1, REG_CMDR, 8'h05); exp_push(0, REG_CMDR, 8'h80);
        n_vec++;
        if (obs_q.size() !== mark + exp_q.size()) begin n_err++; $display("FAIL nak_log_len: got %0d, required %0d", obs_q.size() - mark, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && mark + i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[mark+i] !== exp_q[i]) begin n_err++; $display("FAIL nak_log[%0d]: got %h, required %h", i, obs_q[mark+i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_len();
        int mark;
        logic [5:0] lens[2];
        lens[0] = 6'd0; lens[1] = 6'd33;
        for (int j = 0; j < 2; j++) begin
            mark = obs_q.size();
            send_req(1'b0, 7'h22, lens[j]);
            n_vec++;
            if ({done_o, err_o} !== 2'b11) begin n_err++; $display("FAIL badlen%0d_done: done=%b err=%b, required 1 1", lens[j], done_o, err_o); end
            @(negedge clk_i);
            n_vec++;
            if ({done_o, req_ready_o} !== 2'b01) begin n_err++; $display("FAIL badlen%0d_after: done=%b ready=%b, required 0 1", lens[j], done_o, req_ready_o); end
            n_vec++;
            if (obs_q.size() !== mark || cyc_o !== 1'b0) begin n_err++; $display("FAIL badlen%0d_bus: %0d WB cycles, required 0", lens[j], obs_q.size() - mark); end
        end
    endtask

    task automatic test_reset_mid_read();
        int mark, t;
        logic got, err, saw_wr;
        m_base = 8'd100;
        send_req(1'b1, 7'h22, 6'd32);
        read_bytes(0, 10, 8'd100);
        t = 0;
        while (!rd_valid_o && t < 2000) begin @(negedge clk_i); t++; end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o} !== 20'd0) begin
            n_err++; $display("FAIL midreset_outputs: cyc=%b stb=%b we=%b adr=%h dat=%h rq=%b wr=%b rd=%b done=%b err=%b, required all 0",
                cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o);
        end
        n_vec++;
        if (dbg_state_o !== S_INIT_CSR) begin n_err++; $display("FAIL midreset_state: got %0d, required %0d", dbg_state_o, S_INIT_CSR); end
        @(negedge clk_i);
        mark = obs_q.size();
        rst_i = 1'b0;
        t = 0;
        while (!req_ready_o && t < 2000) begin @(negedge clk_i); t++; end
        exp_q.delete();
        push_init_seq();
        n_vec++;
        if (obs_q.size() !== mark + exp_q.size()) begin n_err++; $display("FAIL reinit_log_len: got %0d, required %0d", obs_q.size() - mark, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && mark + i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[mark+i] !== exp_q[i]) begin n_err++; $display("FAIL reinit_log[%0d]: got %h, required %h", i, obs_q[mark+i], exp_q[i]); end
        end
        m_base = 8'd200;
        send_req(1'b1, 7'h22, 6'd3);
        read_bytes(0, 3, 8'd200);
        wait_done(got, err, saw_wr);
        n_vec++;
        if ({got, err} !== 2'b10) begin n_err++; $display("FAIL post_reset_done: done=%b err=%b, required done=1 err=0", got, err); end
    endtask

    task automatic test_wb_protocol();
        n_vec++;
        if (m_unstable !== 0) begin n_err++; $display("FAIL wb_stable: %0d cycles changed while waiting for ack, required 0", m_unstable); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_bad_len();
        test_reset_mid_read();
        test_wb_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_wb_sequencer.md
I2C_WB_SEQUENCER -- requirements
Module: i2c_wb_sequencer

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter BUS_ID, default 5, I2C bus number written to DPR at init.
REQ-004 SHALL have parameter MAX_LEN, default 32, maximum data bytes per transfer.
REQ-005 clk_i  in  1  single clock; all logic on posedge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 req_valid_i/req_ready_o  in/out  1/1  transfer request handshake.
REQ-008 req_op_i  in  1  0=write, 1=read.
REQ-009 req_addr_i  in  7  I2C slave address.
REQ-010 req_len_i  in  6  byte count, 1..MAX_LEN.
REQ-011 wr_valid_i/wr_ready_o/wr_data_i  in/out/in  1/1/8  write-byte stream.
REQ-012 rd_valid_o/rd_ready_i/rd_data_o  out/in/out  1/1/8  read-byte stream.
REQ-013 done_o  out  1  one-cycle pulse at transfer end; err_o  out  1  valid with done_o, 1 = NAK/arbitration-lost/error.
REQ-014 cyc_o, stb_o, we_o  out  1 each; adr_o  out  WB_ADDR_WIDTH; dat_o  out  WB_DATA_WIDTH; dat_i  in  WB_DATA_WIDTH; ack_i  in  1; Wishbone master to iicmb core.
REQ-015 irq_i  in  1  core interrupt (command complete).

Function
REQ-016 SHALL perform every register access as one WB cycle: cyc_o=stb_o=1 with adr/we/dat stable until ack_i sampled high; deassert all on the following cycle; at most one cycle outstanding.
REQ-017 After reset SHALL run init: write CSR=0xC0 (E|IE), DPR=BUS_ID, CMDR=0x06 (SET_BUS), then WAIT; req_ready_o=0 until init completes.
REQ-018 WAIT SHALL hold until irq_i=1, then WB-read CMDR (offset 2) to clear irq and capture status: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
REQ-019 States: INIT_CSR, INIT_DPR, INIT_CMD, IDLE, START, ADDR_DPR, ADDR_CMD, WR_DPR, WR_CMD, RD_CMD, RD_DPR, RD_OUT, STOP, DONE, plus WAIT reached from each *_CMD/START/STOP and returning to the recorded successor.
REQ-020 IDLE: req_ready_o=1; on req_valid_i&req_ready_o latch op/addr/len, go START (CMDR=0x04).
REQ-021 ADDR: DPR={addr,op}, CMDR=0x01 (WRITE); NAK status -> STOP with err latched.
REQ-022 Write: wr_ready_o=1 only in WR_DPR while no WB cycle active; each accepted byte -> DPR write, CMDR=0x01, WAIT; decrement count; count 0 -> STOP.
REQ-023 Read: CMDR=0x02 (READ_W_AK) for all but last byte, 0x03 (READ_W_NAK) for last; after WAIT, WB-read DPR (offset 1); present in RD_OUT with rd_valid_o=1 held until rd_ready_i.
REQ-024 Any NAK/AL/ERR status -> STOP (CMDR=0x05) then DONE with err_o=1; remaining bytes dropped, wr_ready_o stays 0.
REQ-025 DONE: done_o=1 one cycle, err_o valid same cycle, return IDLE; new request accepted next cycle earliest.
REQ-026 req_len_i=0 or >MAX_LEN SHALL be treated as error: no bus activity, DONE with err_o=1 next cycle.
REQ-027 Byte counter 6 bits, no wrap; compared against 1 to select NAK read.

Reset
REQ-028 rst_i=1 at any time (including mid-transfer or mid-WB-cycle) SHALL next cycle force cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, req_ready_o=wr_ready_o=rd_valid_o=done_o=err_o=0, state=INIT_CSR; init re-runs after release.

Structure
REQ-029 Register offsets (CSR/DPR/CMDR/FSMR), command codes, CSR bit masks, status bit positions SHALL live in shared package iicmb_pkg.
REQ-030 Sub-module wb_master_port SHALL implement the single-cycle WB access (start, addr, we, wdata -> busy, done, rdata).

Verification
REQ-031 Reset release -> WB writes CSR=0xC0, DPR=0x05, CMDR=0x06, read CMDR after irq; req_ready_o rises after.
REQ-032 Write addr 0x22 len 32 data 0..31 -> START, DPR=0x44, 32 DPR/CMDR=0x01 pairs, STOP; done_o with err_o=0; I2C slave sees 0..31.
REQ-033 Read addr 0x22 len 32, slave supplies 100..131 -> 31 CMDR=0x02, last 0x03; rd_data_o 100..131 in order; rd_ready_i stalls honoured.
REQ-034 Write to address 0x23 (no slave) -> NAK after address; STOP issued; done_o with err_o=1; no wr_ready_o.
REQ-035 req_len_i=0 -> no WB cycles, done_o/err_o=1 one cycle later.
REQ-036 rst_i asserted mid read at byte 10 -> bus outputs zero next cycle, init sequence repeats, next request completes correctly.
